// File: rtl/spi_ram_pkg.sv
// Shared command/state encodings for the SPI-side burst RAM slave.
package spi_ram_pkg;

   localparam int CMD_W = 2;

   typedef enum logic [CMD_W-1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/spi_ram_array.sv
// Single-port word array: synchronous write, registered synchronous read.
module spi_ram_array
   import spi_ram_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int MEM_DEPTH = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   // Contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   // The read register doubles as the block's dout, so it keeps its value between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/spi_ram_burst.sv
// SPI-side RAM slave with burst addressing and a ready/valid read-return path.
// Define SPI_RAM_AUTO_INC_EN to post-increment (with wrap) the addresses on each data access.
module spi_ram_burst
   import spi_ram_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int MEM_DEPTH = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W+1:0] din,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [DATA_W-1:0] dout,
   output logic              tx_valid,
   input  logic              tx_ready
);

   localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(MEM_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

   // Addresses outside the array are folded back to word 0.
   function automatic logic [ADDR_W-1:0] addr_clamp(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} >= DEPTH_X) ? '0 : a;
   endfunction

`ifdef SPI_RAM_AUTO_INC_EN
   function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
   endfunction
`endif

   cmd_e              cmd;
   logic [DATA_W-1:0] payload;
   logic              accept;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic              mem_re;
   state_e            state_q;
   state_e            state_d;

   assign cmd      = cmd_e'(din[DATA_W+1:DATA_W]);
   assign payload  = din[DATA_W-1:0];
   assign tx_valid = (state_q == ST_HOLD);
   assign rx_ready = !tx_valid;
   assign accept   = rx_valid && rx_ready;

   assign mem_we   = accept && (cmd == CMD_WR_DATA);
   assign mem_re   = accept && (cmd == CMD_RD_DATA);
   assign mem_addr = (cmd == CMD_WR_DATA) ? wr_addr : rd_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (mem_re)   state_d = ST_HOLD;
         ST_HOLD: if (tx_ready) state_d = ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr <= '0;
         rd_addr <= '0;
      end else if (accept) begin
         case (cmd)
            CMD_WR_ADDR: wr_addr <= addr_clamp(payload[ADDR_W-1:0]);
            CMD_RD_ADDR: rd_addr <= addr_clamp(payload[ADDR_W-1:0]);
`ifdef SPI_RAM_AUTO_INC_EN
            CMD_WR_DATA: wr_addr <= addr_inc(wr_addr);
            CMD_RD_DATA: rd_addr <= addr_inc(rd_addr);
`endif
            default: ;
         endcase
      end
   end

   spi_ram_array #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .MEM_DEPTH(MEM_DEPTH)
   ) u_array (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (mem_we),
      .re   (mem_re),
      .addr (mem_addr),
      .wdata(payload),
      .rdata(dout)
   );

endmodule

// File: doc/spi_ram_burst.md
Name: spi_ram_burst

Overview:
- Parametrised successor to the SPI-side single-port RAM slave.
- Decodes {cmd, payload} words from the SPI slave front-end and performs write-address, write-data, read-address and read-data operations on an internal array.
- Adds generic data/address width and depth, address auto-increment with wrap for burst transfers, and a ready/valid back-pressure handshake on the read-data return path.
- Sits between the SPI slave shift logic (rx side) and the SPI transmit serialiser (tx side).

Parameters:
- DATA_W, 8, width of a memory word and of the din payload field.
- ADDR_W, 8, width of the address registers; must satisfy ADDR_W <= DATA_W.
- MEM_DEPTH, 256, number of words; must satisfy 2 <= MEM_DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  DATA_W+2  command word: din[DATA_W+1:DATA_W] = cmd, din[DATA_W-1:0] = payload.
- rx_valid  in  1  din valid this cycle.
- rx_ready  out  1  block can accept din; combinational, = !tx_valid.
- dout  out  DATA_W  read data.
- tx_valid  out  1  dout valid; held until consumed.
- tx_ready  in  1  downstream consumes dout when high with tx_valid.

Behaviour:
- Reset (async assert, sync release): dout=0, tx_valid=0, wr_addr=0, rd_addr=0. Memory contents are not reset. Reset mid-hold drops tx_valid immediately.
- Accept condition: rx_valid && rx_ready at a rising edge. Non-accepted words are ignored with no state change.
- cmd 00 (WR_ADDR): wr_addr <= payload[ADDR_W-1:0]; if that value >= MEM_DEPTH, wr_addr <= 0.
- cmd 01 (WR_DATA): mem[wr_addr] <= payload; wr_addr advances per the auto-increment rule.
- cmd 10 (RD_ADDR): rd_addr <= payload[ADDR_W-1:0], clamped to 0 if >= MEM_DEPTH.
- cmd 11 (RD_DATA): dout <= mem[rd_addr] and tx_valid <= 1 on the same edge (1-cycle latency); rd_addr advances per the auto-increment rule. The payload is ignored.
- Hold state: while tx_valid=1, dout is stable and rx_ready=0. On an edge where tx_valid && tx_ready, tx_valid <= 0 and dout keeps its last value. Minimum spacing between accepted reads is therefore 2 cycles.
- Two-state FSM:
  - IDLE (tx_valid=0) goes to HOLD on an accepted RD_DATA.
  - HOLD (tx_valid=1) goes to IDLE on tx_ready.
- Wrap: an address increment from MEM_DEPTH-1 goes to 0.
- Write-then-read of the same address in consecutive accepted cycles returns the new data; the write lands at the earlier edge.
- tx_ready while tx_valid=0 has no effect.

Optional Feature:
- Macro: SPI_RAM_AUTO_INC_EN.
- Defined: WR_DATA post-increments wr_addr and RD_DATA post-increments rd_addr, both with wrap at MEM_DEPTH.
- Undefined: addresses change only via cmd 00/10, giving legacy single-access behaviour. All handshake behaviour is unchanged.

Decomposition:
- Package spi_ram_pkg:
  - cmd enum {CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11}.
  - FSM state enum {ST_IDLE, ST_HOLD}.
  - CMD_W=2 constant.
- One sub-module spi_ram_array, parametrised by DATA_W/ADDR_W/MEM_DEPTH: synchronous write, synchronous read, single port. Address and handshake logic stays in the top.

Test Plan:
- Reset then idle: pulse rst_n low asynchronously mid-cycle -> dout=0, tx_valid=0 and rx_ready=1 immediately; tx_ready toggling produces no change.
- Single write/read: din=00_0x12, 01_0xA5, 10_0x12, 11_xx with tx_ready=1 -> one cycle after the RD_DATA accept, dout=0xA5 and tx_valid=1 for exactly 1 cycle.
- Back-pressure: issue RD_DATA with tx_ready=0 for 5 cycles -> tx_valid and dout held, rx_ready=0, a concurrent WR_ADDR 00_0x40 is ignored (wr_addr unchanged); tx_ready=1 -> tx_valid falls next edge.
- Burst with SPI_RAM_AUTO_INC_EN: wr_addr=0xFE, write 0x11, 0x22, 0x33; rd_addr=0xFE; read x3 -> returns 0x11, 0x22, 0x33, with the last word at address 0x00 (wrap).
- Without macro: the same sequence -> all three writes land at 0xFE; reads return 0x33 three times.
- MEM_DEPTH=200 build: WR_ADDR 0xF0 then WR_DATA 0x5A, RD_ADDR 0x00, RD_DATA -> returns 0x5A (out-of-range address clamps to 0).
